// File: rtl/nes_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nes_mem_arbiter_if
// Brief    : Multi-channel req/ack memory bus between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface nes_mem_arbiter_if #(
  parameter int CHANNELS = 3,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8
);
  localparam int ID_W = $clog2(CHANNELS);

  logic [CHANNELS-1:0]        req;
  logic [CHANNELS-1:0]        we;
  logic [CHANNELS*ADDR_W-1:0] addr;
  logic [CHANNELS*DATA_W-1:0] wdata;
  logic [CHANNELS-1:0]        ack;
  logic [DATA_W-1:0]          rdata;
  logic [ID_W-1:0]            gnt_id;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, gnt_id
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, gnt_id
  );
endinterface
`default_nettype wire

// File: rtl/nes_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nes_mem_arbiter
// Brief    : Shared single-port memory, one access per clock, 1-cycle read
//            latency. Define NES_MEM_ARB_RR_EN for round-robin arbitration,
//            otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module nes_mem_arbiter #(
  parameter int    CHANNELS  = 3,
  parameter int    ADDR_W    = 16,
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 65536,
  parameter string INIT_FILE = ""
) (
  input  wire logic         pin_clock,
  input  wire logic         pin_reset,
  nes_mem_arbiter_if.slave  bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int ID_W = $clog2(CHANNELS);

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [CHANNELS-1:0] r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [ID_W-1:0]     r_gnt_id;

  logic                w_gnt_valid;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [AW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr;

`ifdef NES_MEM_ARB_RR_EN
  logic [ID_W-1:0] r_rr_ptr;
  int              w_cand;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_cand = (int'(r_rr_ptr) + k) % CHANNELS;
      if (!w_gnt_valid && bus.req[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = ID_W'(w_cand);
      end
    end
  end

  always_ff @(posedge pin_clock or posedge pin_reset) begin
    if (pin_reset) begin
      r_rr_ptr <= ID_W'(CHANNELS - 1);
    end else if (w_gnt_valid) begin
      r_rr_ptr <= w_gnt_idx;
    end
  end
`else
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (bus.req[c]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = ID_W'(c);
      end
    end
  end
`endif

  // Upper address bits are dropped, so addresses alias modulo DEPTH.
  assign w_idx   = bus.addr[int'(w_gnt_idx)*ADDR_W +: AW];
  assign w_wdata = bus.wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_wr    = w_gnt_valid && bus.we[w_gnt_idx] && !pin_reset;

  always_ff @(posedge pin_clock) begin
    if (w_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  // Read-before-write: a write grant returns the word it replaces.
  always_ff @(posedge pin_clock or posedge pin_reset) begin
    if (pin_reset) begin
      r_ack    <= '0;
      r_rdata  <= '0;
      r_gnt_id <= '0;
    end else begin
      r_ack <= '0;
      if (w_gnt_valid) begin
        r_ack[w_gnt_idx] <= 1'b1;
        r_rdata          <= r_mem[w_idx];
        r_gnt_id         <= w_gnt_idx;
      end
    end
  end

  assign bus.ack    = r_ack;
  assign bus.rdata  = r_rdata;
  assign bus.gnt_id = r_gnt_id;
endmodule
`default_nettype wire
